// File: rtl/ws2812_pkg.sv
// Shared WS2812 line timing, decode thresholds and receiver state encoding.
package ws2812_pkg;

  // Driver bit timing in 100 MHz cycles, shared with ws2812_driver
  localparam int unsigned T0H = 35;
  localparam int unsigned T0L = 80;
  localparam int unsigned T1H = 70;
  localparam int unsigned T1L = 60;
  localparam int unsigned RES = 5000;

  localparam int unsigned T_MIN_H_DEF  = 10;
  localparam int unsigned T_THRESH_DEF = 52;
  localparam int unsigned T_MAX_H_DEF  = 200;

  localparam int unsigned PIXEL_W   = 24;
  localparam int unsigned CNT_W     = 13;
  localparam int unsigned BIT_CNT_W = 5;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    IDLE   = 2'd1,
    MEAS_H = 2'd2,
    MEAS_L = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/ws2812_edge_sync.sv
// Two-flop synchronizer for an asynchronous line plus rise/fall strobes
// taken against a registered copy of the synchronized level.
module ws2812_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic din_s,
  output logic rise_c,
  output logic fall_c
);

  logic meta_q;
  logic din_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      din_s  <= 1'b0;
      din_d  <= 1'b0;
    end else begin
      meta_q <= din;
      din_s  <= meta_q;
      din_d  <= din_s;
    end
  end

  assign rise_c = din_s & ~din_d;
  assign fall_c = ~din_s & din_d;

endmodule

// File: rtl/ws2812_receiver.sv
// WS2812 line decoder: pulse-width bit classification, pixel assembly and
// frame summary. Define WS2812_FWD_EN for daisy-chain pass-through on dout.
module ws2812_receiver
  import ws2812_pkg::*;
#(
  parameter int unsigned NUM_LED    = 8,
  parameter int unsigned IDX_W      = 6,
  parameter int unsigned T_MIN_H    = T_MIN_H_DEF,
  parameter int unsigned T_THRESH   = T_THRESH_DEF,
  parameter int unsigned T_MAX_H    = T_MAX_H_DEF,
  parameter int unsigned RES_CYCLES = RES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din,
  output logic [PIXEL_W-1:0] pixel_data,
  output logic               pixel_valid,
  output logic [IDX_W-1:0]   pixel_idx,
  output logic               frame_done,
  output logic [IDX_W-1:0]   frame_count,
  output logic               err,
  output logic               busy,
  output logic               dout
);

  localparam logic [CNT_W-1:0]     MIN_H   = CNT_W'(T_MIN_H);
  localparam logic [CNT_W-1:0]     THRESH  = CNT_W'(T_THRESH);
  localparam logic [CNT_W-1:0]     MAX_H   = CNT_W'(T_MAX_H);
  localparam logic [CNT_W-1:0]     RES_M1  = CNT_W'(RES_CYCLES - 1);
  localparam logic [IDX_W-1:0]     MAX_PIX = IDX_W'(NUM_LED);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(PIXEL_W - 1);

  logic din_s;
  logic rise_c;
  logic fall_c;

  ws2812_edge_sync u_edge_sync (
    .clk    (clk),
    .reset  (reset),
    .din    (din),
    .din_s  (din_s),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      high_q, high_d;
  logic [CNT_W-1:0]      low_q, low_d;
  logic [BIT_CNT_W-1:0]  bit_q, bit_d;
  logic [IDX_W-1:0]      pix_q, pix_d;
  logic [PIXEL_W-1:0]    shift_q, shift_d;
  logic [PIXEL_W-1:0]    shifted_c;
  logic                  abort_c;

  logic [PIXEL_W-1:0]    data_d;
  logic                  valid_d;
  logic [IDX_W-1:0]      idx_d;
  logic                  done_d;
  logic [IDX_W-1:0]      count_d;
  logic                  err_d;
  logic                  busy_d;

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    high_d    = high_q;
    low_d     = low_q;
    bit_d     = bit_q;
    pix_d     = pix_q;
    shift_d   = shift_q;
    data_d    = pixel_data;
    valid_d   = 1'b0;
    idx_d     = pixel_idx;
    done_d    = 1'b0;
    count_d   = frame_count;
    err_d     = 1'b0;
    busy_d    = busy;
    abort_c   = 1'b0;
    shifted_c = {shift_q[PIXEL_W-2:0], (high_q >= THRESH)};

    unique case (state_q)
      SYNC: begin
        busy_d = 1'b0;
        if (din_s) begin
          low_d = '0;
        end else if (low_q >= RES_M1) begin
          low_d   = '0;
          state_d = IDLE;
        end else begin
          low_d = sat_inc(low_q);
        end
      end

      IDLE: begin
        if (rise_c) begin
          high_d  = CNT_W'(1);
          busy_d  = 1'b1;
          state_d = MEAS_H;
        end
      end

      MEAS_H: begin
        if (high_q > MAX_H) begin
          err_d   = 1'b1;
          abort_c = 1'b1;
        end else if (fall_c) begin
          if (high_q < MIN_H) begin
            err_d   = 1'b1;
            abort_c = 1'b1;
          end else begin
            shift_d = shifted_c;
            low_d   = CNT_W'(1);
            state_d = MEAS_L;
            if (bit_q == LAST_BIT) begin
              bit_d = '0;
              // Pixels beyond NUM_LED are still consumed but only flagged
              if (pix_q == MAX_PIX) begin
                err_d = 1'b1;
              end else begin
                data_d  = shifted_c;
                valid_d = 1'b1;
                idx_d   = pix_q;
                pix_d   = pix_q + IDX_W'(1);
              end
            end else begin
              bit_d = bit_q + BIT_CNT_W'(1);
            end
          end
        end else begin
          high_d = sat_inc(high_q);
        end
      end

      MEAS_L: begin
        if (rise_c) begin
          high_d  = CNT_W'(1);
          state_d = MEAS_H;
        end else if (low_q >= RES_M1) begin
          done_d  = 1'b1;
          count_d = pix_q;
          err_d   = (bit_q != '0);
          busy_d  = 1'b0;
          pix_d   = '0;
          bit_d   = '0;
          shift_d = '0;
          low_d   = '0;
          state_d = IDLE;
        end else begin
          low_d = sat_inc(low_q);
        end
      end
    endcase

    // Line errors drop the frame and require a full reset gap to resync
    if (abort_c) begin
      state_d = SYNC;
      busy_d  = 1'b0;
      pix_d   = '0;
      bit_d   = '0;
      shift_d = '0;
      low_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SYNC;
      high_q      <= '0;
      low_q       <= '0;
      bit_q       <= '0;
      pix_q       <= '0;
      shift_q     <= '0;
      pixel_data  <= '0;
      pixel_valid <= 1'b0;
      pixel_idx   <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      err         <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      high_q      <= high_d;
      low_q       <= low_d;
      bit_q       <= bit_d;
      pix_q       <= pix_d;
      shift_q     <= shift_d;
      pixel_data  <= data_d;
      pixel_valid <= valid_d;
      pixel_idx   <= idx_d;
      frame_done  <= done_d;
      frame_count <= count_d;
      err         <= err_d;
      busy        <= busy_d;
    end
  end

`ifdef WS2812_FWD_EN
  // Own pixel is swallowed; everything after it is re-timed onto dout
  always_ff @(posedge clk) begin
    if (reset) begin
      dout <= 1'b0;
    end else begin
      dout <= (pix_d != '0) ? din_s : 1'b0;
    end
  end
`else
  assign dout = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_receiver.sv
// Self-checking bench for ws2812_receiver: driver-timed stimulus with a
// scoreboard of expected pixel, frame and error events.
module tb_ws2812_receiver;

  localparam int unsigned NUM_LED = 8;
  localparam int unsigned IDX_W   = 6;
  localparam int unsigned H0 = 35;
  localparam int unsigned H1 = 70;
  localparam int unsigned L0 = 80;
  localparam int unsigned L1 = 60;
  localparam int unsigned END_LOW = 5060;
`ifdef WS2812_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             din;
  logic [23:0]      pixel_data;
  logic             pixel_valid;
  logic [IDX_W-1:0] pixel_idx;
  logic             frame_done;
  logic [IDX_W-1:0] frame_count;
  logic             err;
  logic             busy;
  logic             dout;

  always #5 clk = ~clk;

  ws2812_receiver #(.NUM_LED(NUM_LED), .IDX_W(IDX_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .pixel_idx   (pixel_idx),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .err         (err),
    .busy        (busy),
    .dout        (dout)
  );

  typedef struct {
    logic [23:0]      data;
    logic [IDX_W-1:0] idx;
  } pix_exp_t;

  typedef struct {
    logic [IDX_W-1:0] count;
    logic             with_err;
  } frm_exp_t;

  typedef struct {
    logic [23:0] data;
    int unsigned h0;
    int unsigned h1;
    logic [23:0] exp;
  } vec_t;

  pix_exp_t    pix_q[$];
  frm_exp_t    frm_q[$];
  int          err_exp  = 0;
  int          checks   = 0;
  int          errors   = 0;
  int          fwd_mode = 1;
  int          dout_bad = 0;
  logic [2:0]  hist     = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int unsigned n);
    @(posedge clk);
    #1 din = v;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic send_bits(input logic [23:0] d, input int unsigned n,
                           input int unsigned h0, input int unsigned h1);
    for (int i = 23; i > 23 - int'(n); i--) begin
      if (d[i]) begin
        drive(1'b1, h1);
        drive(1'b0, L1);
      end else begin
        drive(1'b1, h0);
        drive(1'b0, L0);
      end
    end
  endtask

  // Scoreboard consumer, sampled away from the active edge
  always @(negedge clk) begin
    pix_exp_t pe;
    frm_exp_t fe;
    logic     exp_dout;
    if (pixel_valid) begin
      check("valid_err_excl", 64'(err), 64'd0);
      if (pix_q.size() == 0) begin
        check("pix_unexpected", 64'(pixel_valid), 64'd0);
      end else begin
        pe = pix_q.pop_front();
        check("pixel", 64'({pixel_data, pixel_idx}), 64'({pe.data, pe.idx}));
      end
    end
    if (frame_done) begin
      if (frm_q.size() == 0) begin
        check("frame_unexpected", 64'(frame_done), 64'd0);
      end else begin
        fe = frm_q.pop_front();
        check("frame", 64'({frame_count, err}), 64'({fe.count, fe.with_err}));
      end
    end else if (err) begin
      if (err_exp > 0) begin
        check("err_expected", 64'(err), 64'd1);
        err_exp--;
      end else begin
        check("err_unexpected", 64'(err), 64'd0);
      end
    end
    exp_dout = (FWD && fwd_mode == 2) ? hist[2] : 1'b0;
    if (fwd_mode != 0 && dout !== exp_dout) dout_bad++;
    hist = {hist[1:0], din};
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[5];
    logic [23:0] d;

    vecs[0] = '{24'hA50FC3, H0,  H1,  24'hA50FC3};
    vecs[1] = '{24'h5A5A5A, 51,  52,  24'h5A5A5A};
    vecs[2] = '{24'hC3C3C3, 10,  200, 24'hC3C3C3};
    vecs[3] = '{24'h123456, 52,  52,  24'hFFFFFF};
    vecs[4] = '{24'hFFFFFF, H0,  51,  24'h000000};

    din   = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", 64'({pixel_data, pixel_valid, pixel_idx, frame_done,
                              frame_count, err, busy, dout}), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    drive(1'b0, END_LOW);

    // Frame A: width table, then counted pixels through overflow
    frm_q.push_back('{IDX_W'(NUM_LED), 1'b0});
    for (int i = 0; i < 5; i++) begin
      pix_q.push_back('{vecs[i].exp, IDX_W'(i)});
      send_bits(vecs[i].data, 24, vecs[i].h0, vecs[i].h1);
      if (i == 0) begin
        @(negedge clk);
        check("busy_mid_frame", 64'(busy), 64'd1);
        fwd_mode = 2;
      end
    end
    for (int i = 5; i < 9; i++) begin
      d = 24'(24'h010203 * i);
      if (i < int'(NUM_LED)) pix_q.push_back('{d, IDX_W'(i)});
      else err_exp++;
      send_bits(d, 24, H0, H1);
    end
    drive(1'b0, END_LOW);
    fwd_mode = 1;
    @(negedge clk);
    check("busy_after_frame", 64'(busy), 64'd0);

    // Partial pixel at frame end
    frm_q.push_back('{IDX_W'(0), 1'b1});
    send_bits(24'hB4D000, 12, H0, H1);
    drive(1'b0, END_LOW);

    // Over-long high mid-pixel; following bits ignored until resync
    err_exp++;
    send_bits(24'hA00000, 5, H0, H1);
    drive(1'b1, 250);
    send_bits(24'hF0F000, 8, H0, H1);
    drive(1'b0, END_LOW);

    // Glitch one cycle below the minimum high width
    err_exp++;
    drive(1'b1, 9);
    drive(1'b0, END_LOW);

    // Frame B: reset lands in the third pixel
    pix_q.push_back('{24'h00FF00, IDX_W'(0)});
    send_bits(24'h00FF00, 24, H0, H1);
    fwd_mode = 2;
    pix_q.push_back('{24'h3C3C3C, IDX_W'(1)});
    send_bits(24'h3C3C3C, 24, H0, H1);
    send_bits(24'h9E0000, 10, H0, H1);
    drive(1'b1, 20);
    fwd_mode = 0;
    @(posedge clk);
    #1 reset = 1'b1;
    din = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset_mid_frame", 64'({pixel_data, pixel_valid, pixel_idx, frame_done,
                                  frame_count, err, busy, dout}), 64'd0);
    fwd_mode = 1;
    @(posedge clk);
    #1 reset = 1'b0;

    // Not yet resynchronised: this pixel must be dropped
    send_bits(24'h13579B, 24, H0, H1);
    drive(1'b0, END_LOW);
    pix_q.push_back('{24'h2468AC, IDX_W'(0)});
    frm_q.push_back('{IDX_W'(1), 1'b0});
    send_bits(24'h2468AC, 24, H0, H1);
    drive(1'b0, END_LOW);
    drive(1'b0, 10);

    @(negedge clk);
    check("pix_left", 64'(pix_q.size()), 64'd0);
    check("frm_left", 64'(frm_q.size()), 64'd0);
    check("err_left", 64'(err_exp), 64'd0);
    check("dout", 64'(dout_bad), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ws2812_receiver.md
Name: ws2812_receiver

Overview:
Decodes a WS2812 serial line back into 24-bit pixel words. It is the receive end of the same protocol that ws2812_driver transmits.
- Measures the width of each high pulse to classify bits; a long low period marks end of frame.
- Emits one pixel word per 24 bits, with its index, plus a per-frame summary.
- Used for driver loopback self-test and for daisy-chain monitoring on the 100 MHz fabric clock.

Parameters:
NUM_LED, 8, maximum pixels accepted per frame; extra pixels are flagged.
IDX_W, 6, width of pixel_idx and frame_count.
T_MIN_H, 10, high pulses shorter than this many cycles are glitches.
T_THRESH, 52, high width >= T_THRESH decodes as 1, otherwise 0 (separates 35 and 70 cycles).
T_MAX_H, 200, high width above this is a line error.
RES_CYCLES, 5000, low time (50 us @ 100 MHz) that ends a frame.

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  synchronous, active-high reset
din  in  1  asynchronous WS2812 data line
pixel_data  out  24  last decoded pixel; first received bit is pixel_data[23]
pixel_valid  out  1  one-cycle strobe, pixel_data/pixel_idx valid
pixel_idx  out  IDX_W  index of pixel in frame, 0-based
frame_done  out  1  one-cycle strobe at end of frame
frame_count  out  IDX_W  pixels received in frame, valid with frame_done; saturates at NUM_LED
err  out  1  one-cycle strobe on any protocol error
busy  out  1  high while a frame is in progress (first rising edge to frame_done/err)
dout  out  1  forward output (feature only; tied 0 otherwise)

Behaviour:
- Reset values: all outputs 0, state SYNC, all counters 0.
- Reset is honoured on any cycle, including mid-frame. No strobe fires on the reset cycle or the following cycle.
- din passes through a 2-FF synchronizer to give din_s; all timing is measured on din_s. Pin-to-din_s latency is 2 cycles.
- Edges are detected against a registered copy of din_s.
- SYNC: counts consecutive low cycles. Reaching RES_CYCLES -> IDLE. A high input restarts the count. Entered after reset and after any error.
- IDLE: rising edge -> MEAS_H, high_cnt=1, busy=1.
- MEAS_H: high_cnt increments each high cycle.
  - high_cnt > T_MAX_H -> err, discard partial pixel, -> SYNC.
  - On a falling edge with high_cnt < T_MIN_H -> err, -> SYNC.
  - On any other falling edge: bit = (high_cnt >= T_THRESH); shift it into the shift register MSB-first; bit_cnt++; low_cnt=1; -> MEAS_L.
- 24th bit: pixel_data <= shifted word, pixel_valid=1 on the next cycle, pixel_idx=pix_cnt; then pix_cnt++ and bit_cnt=0.
  - If pix_cnt is already NUM_LED, pixel_valid is suppressed and err pulses once per excess pixel; frame_count stays NUM_LED.
- MEAS_L: low_cnt increments.
  - Rising edge before RES_CYCLES -> MEAS_H.
  - low_cnt == RES_CYCLES with bit_cnt==0 -> frame_done=1, frame_count=pix_cnt, busy=0, pix_cnt=0, -> IDLE.
  - low_cnt == RES_CYCLES with bit_cnt!=0 -> err=1 and frame_done=1 in the same cycle, frame_count=pix_cnt (partial pixel excluded), -> IDLE.
- Low width is not checked between bits; only the reset threshold matters.
- Counters are 13 bits wide and saturate (never wrap). high_cnt is only compared, never wraps.
- Simultaneous events: a 24th-bit pixel_valid and an overflow err never coincide (mutually exclusive). frame_done may coincide with err only in the partial-pixel case.

Optional Feature:
WS2812_FWD_EN
- Defined: chain pass-through. While pix_cnt==0 (own pixel), dout=0. After the first pixel is captured, dout follows din_s registered, a 3-cycle total delay. dout returns to 0 at frame_done or err. Decode of all pixels continues as above.
- Undefined: dout tied 0, no forwarding logic.

Decomposition:
- Shared package ws2812_pkg: T0H/T0L/T1H/T1L/RES timing constants (shared with ws2812_driver), T_MIN_H/T_THRESH/T_MAX_H defaults, PIXEL_W=24, state encoding SYNC/IDLE/MEAS_H/MEAS_L.
- One natural sub-module: ws2812_edge_sync (2-FF synchronizer plus rise/fall strobes), reusable by other line monitors.

Test Plan:
- Reset released, din low 5000 cycles, then one pixel 24'hA50FC3 with driver timing (high 35/70, low 80/60) -> pixel_valid once, pixel_data=24'hA50FC3, pixel_idx=0. After 50 us low -> frame_done, frame_count=1.
- Loopback from ws2812_driver, NUM_LED=8, rgb_data pixels i=24'h010203*i -> 8 pixel_valid with idx 0..7 and matching data, then frame_done with frame_count=8, err never asserted.
- 12 bits then 60 us low -> no pixel_valid; err and frame_done in the same cycle, frame_count=0.
- 250-cycle high pulse mid-pixel -> err. Next pixel is ignored until 5000 low cycles elapse, then decodes correctly.
- 9 pixels with NUM_LED=8 -> 8 pixel_valid, one err at the 9th pixel, frame_count=8. Reset asserted mid-pixel-3 -> all outputs 0, SYNC required before the next decode.
- WS2812_FWD_EN with 3 pixels -> dout stays 0 through pixel 0, then reproduces pixels 1-2 waveform delayed 3 cycles, and is 0 after frame_done.
